rat_flag_intr_unit: RTL and testbench
=====================================

// Module: rat_flag_intr_unit
// PURPOSE
//  Flag and interrupt register stage for the RAT CPU. Consumes the control unit's
//  flag strobes (FLG_C_*, FLG_Z_LD, FLG_SHAD_LD, FLG_LD_SEL, I_SET/I_CLR).
//  Feeds C_FLAG, Z_FLAG and INTR back into the control unit.
//  Owns the C/Z flags, their shadow copies for interrupt entry/return, the
//  interrupt-enable flag, and the synchronizer/latch for the external interrupt pin.
// PARAMETERS
//  SYNC_STAGES  2  flops in INT_IN synchronizer chain; legal range 2..4
//  EDGE_MODE    1  1 = latch rising edge of synced INT_IN; 0 = pending follows synced level
// PORTS
//  CLK          in   1  system clock, all state updates on rising edge
//  RESET_N      in   1  asynchronous, active-low reset
//  ALU_C        in   1  carry result from ALU
//  ALU_Z        in   1  zero result from ALU
//  FLG_C_SET    in   1  force C=1
//  FLG_C_CLR    in   1  force C=0
//  FLG_C_LD     in   1  load C from selected source
//  FLG_Z_LD     in   1  load Z from selected source
//  FLG_LD_SEL   in   1  load source: 0 = ALU_C/ALU_Z, 1 = shadow flags (RETI)
//  FLG_SHAD_LD  in   1  copy current C/Z into shadow regs (interrupt entry)
//  I_SET        in   1  set interrupt enable
//  I_CLR        in   1  clear interrupt enable
//  INT_ACK      in   1  control unit has entered the interrupt cycle; clears pending
//  INT_IN       in   1  external interrupt pin, asynchronous to CLK
//  C_FLAG       out  1  carry flag
//  Z_FLAG       out  1  zero flag
//  I_FLAG       out  1  interrupt enable
//  INT_PENDING  out  1  latched interrupt request, independent of I_FLAG
//  INTR         out  1  INT_PENDING & I_FLAG, combinational from registers only
// BEHAVIOUR
//  Reset:
//   - RESET_N low clears C, Z, SHAD_C, SHAD_Z, I_FLAG, pending, all sync flops and
//     the edge-history flop, immediately.
//   - All outputs read 0 while RESET_N is low.
//  C update, per rising edge, priority CLR > SET > LD:
//   - CLR: C <= 0. SET: C <= 1. LD: C <= FLG_LD_SEL ? SHAD_C : ALU_C.
//   - With no strobe, C holds its value.
//  Z update:
//   - FLG_Z_LD: Z <= FLG_LD_SEL ? SHAD_Z : ALU_Z.
//   - Otherwise Z holds. No set/clear strobes exist for Z.
//  Shadow regs:
//   - FLG_SHAD_LD captures the pre-edge C/Z, i.e. the value before any same-cycle
//     C/Z update.
//   - FLG_SHAD_LD together with a FLG_LD_SEL=1 load: flags get the old shadow,
//     and the shadow gets the old flags (swap).
//  I_FLAG:
//   - I_CLR wins over I_SET. Neither asserted: hold.
//   - INTR is never gated by anything except I_FLAG.
//  Interrupt input path:
//   - INT_IN passes through SYNC_STAGES flops, giving int_s. int_d is int_s delayed
//     by one cycle.
//   - EDGE_MODE=1: pending sets on int_s & ~int_d and clears on INT_ACK.
//     A new edge in the same cycle as INT_ACK wins (pending stays 1).
//   - EDGE_MODE=0: pending <= int_s every cycle; INT_ACK has no effect.
//  Latency:
//   - Edge mode: INT_IN rising edge (meeting setup) to INT_PENDING=1 is
//     SYNC_STAGES+1 clock edges.
//   - INTR follows INT_PENDING/I_FLAG with zero added cycles.
//  Lost and held-off events:
//   - A pulse on INT_IN shorter than one CLK period may be missed. This is
//     permitted and documented.
//   - Edges arriving while pending=1 merge into one request (no counting).
//   - INT_IN held high through reset release yields exactly one pending,
//     SYNC_STAGES+1 edges after release, because int_d resets to 0.
//  Reset mid-operation:
//   - An outstanding pending is discarded.
//   - Shadow contents are lost; no restore is possible after reset.
// TESTING
//  - Reset: drive all strobes 1 with RESET_N=0 -> every output 0 while low and on
//    the first edge after release.
//  - C priority: FLG_C_SET=FLG_C_CLR=FLG_C_LD=1, ALU_C=1 -> C_FLAG=0.
//    Then SET+LD with ALU_C=0 -> C_FLAG=1.
//  - Swap: C=1, Z=0, shadow=(0,1); assert FLG_SHAD_LD, FLG_C_LD, FLG_Z_LD,
//    FLG_LD_SEL=1 for one cycle -> C=0, Z=1, shadow=(1,0).
//  - Edge latency, SYNC_STAGES=2, I_FLAG=1: raise INT_IN before edge n
//    -> INT_PENDING and INTR high after edge n+2. Hold INT_IN high, pulse INT_ACK
//    -> pending 0 and stays 0.
//  - ACK collision: second rising edge of int_s in the same cycle as INT_ACK
//    -> INT_PENDING remains 1.
//  - Masking: pending=1, I_SET=I_CLR=1 -> I_FLAG=0, INTR=0, INT_PENDING=1.
//    Then I_SET alone -> INTR=1 the next cycle.

Source files
------------

// File: rtl/rat_flag_intr_unit.sv
`default_nettype none
// ============================================================================
// Module      : rat_flag_intr_unit
// Description : Flag and interrupt register stage for the RAT CPU.
//               Holds the carry/zero flags and their shadow copies used on
//               interrupt entry and return, the interrupt-enable flag, and
//               the synchronizer plus request latch for the external
//               interrupt pin. C_FLAG, Z_FLAG and INTR go back to the
//               control unit.
// Parameters  : SYNC_STAGES  flops in the INT_IN synchronizer (2..4)
//               EDGE_MODE    1 = latch rising edge of synced INT_IN,
//                            0 = pending follows synced level
// Ports       : CLK          system clock, rising edge
//               RESET_N      asynchronous active-low reset
//               ALU_C/ALU_Z  carry / zero results from the ALU
//               FLG_C_SET/FLG_C_CLR/FLG_C_LD  carry strobes (CLR > SET > LD)
//               FLG_Z_LD     zero-flag load strobe
//               FLG_LD_SEL   load source: 0 = ALU, 1 = shadow flags (RETI)
//               FLG_SHAD_LD  copy current C/Z into the shadow registers
//               I_SET/I_CLR  interrupt-enable strobes (CLR wins)
//               INT_ACK      interrupt cycle entered, clears pending
//               INT_IN       external interrupt pin, asynchronous
//               C_FLAG/Z_FLAG/I_FLAG  flag outputs
//               INT_PENDING  latched request, independent of I_FLAG
//               INTR         INT_PENDING & I_FLAG
// Revision    : 1.0 - initial release
// ============================================================================
module rat_flag_intr_unit #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_MODE   = 1'b1
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic ALU_C,
  input  logic ALU_Z,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic FLG_C_LD,
  input  logic FLG_Z_LD,
  input  logic FLG_LD_SEL,
  input  logic FLG_SHAD_LD,
  input  logic I_SET,
  input  logic I_CLR,
  input  logic INT_ACK,
  input  logic INT_IN,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic I_FLAG,
  output logic INT_PENDING,
  output logic INTR
);

  // --------------------------------------------------------------------------
  // Flag registers
  // --------------------------------------------------------------------------
  logic r_c;
  logic r_z;
  logic r_shad_c;
  logic r_shad_z;
  logic r_i;
  logic w_c_next;
  logic w_z_next;
  logic w_i_next;

  always_comb begin
    w_c_next = r_c;
    if (FLG_C_CLR) begin
      w_c_next = 1'b0;
    end else if (FLG_C_SET) begin
      w_c_next = 1'b1;
    end else if (FLG_C_LD) begin
      w_c_next = FLG_LD_SEL ? r_shad_c : ALU_C;
    end
  end

  always_comb begin
    w_z_next = r_z;
    if (FLG_Z_LD) begin
      w_z_next = FLG_LD_SEL ? r_shad_z : ALU_Z;
    end
  end

  always_comb begin
    w_i_next = r_i;
    if (I_CLR) begin
      w_i_next = 1'b0;
    end else if (I_SET) begin
      w_i_next = 1'b1;
    end
  end

  // The shadow copy samples r_c/r_z, i.e. the pre-edge flags. Combined with
  // a shadow-sourced load in the same cycle this yields a clean swap.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_shad_c <= 1'b0;
      r_shad_z <= 1'b0;
      r_i      <= 1'b0;
    end else begin
      r_c <= w_c_next;
      r_z <= w_z_next;
      r_i <= w_i_next;
      if (FLG_SHAD_LD) begin
        r_shad_c <= r_c;
        r_shad_z <= r_z;
      end
    end
  end

  // --------------------------------------------------------------------------
  // INT_IN synchronizer: bit 0 samples the pin, the top bit is int_s.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_int_s;
  logic                   r_pending;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], INT_IN};
    end
  end

  assign w_int_s = r_sync[SYNC_STAGES-1];

  generate
    if (EDGE_MODE) begin : g_edge
      // int_d resets to 0, so a pin already high at reset release still
      // produces exactly one request.
      logic r_int_d;
      logic w_int_rise;

      assign w_int_rise = w_int_s & ~r_int_d;

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_int_d   <= 1'b0;
          r_pending <= 1'b0;
        end else begin
          r_int_d <= w_int_s;
          // A fresh edge outranks an acknowledge in the same cycle, so the
          // new request is not lost. Edges while pending merge.
          if (w_int_rise) begin
            r_pending <= 1'b1;
          end else if (INT_ACK) begin
            r_pending <= 1'b0;
          end
        end
      end
    end else begin : g_level
      // Level mode: the request mirrors the pin; acknowledge is meaningless.
      logic w_unused_ack;
      assign w_unused_ack = INT_ACK;

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_pending <= 1'b0;
        end else begin
          r_pending <= w_int_s;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs: straight from registers, INTR gated only by the enable flag.
  // --------------------------------------------------------------------------
  assign C_FLAG      = r_c;
  assign Z_FLAG      = r_z;
  assign I_FLAG      = r_i;
  assign INT_PENDING = r_pending;
  assign INTR        = r_pending & r_i;

endmodule
`default_nettype wire

// File: tb/tb_rat_flag_intr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rat_flag_intr_unit
// Description : Self-checking bench for rat_flag_intr_unit. Two instances
//               share stimulus: an edge-mode unit with two sync stages and a
//               level-mode unit with three. Directed scenarios are followed
//               by random strobe traffic, all compared against a reference
//               model that keeps the history of INT_IN samples and derives
//               the synchronized view from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rat_flag_intr_unit;

  logic CLK;
  logic RESET_N;
  logic ALU_C, ALU_Z;
  logic FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD;
  logic I_SET, I_CLR, INT_ACK, INT_IN;

  logic C_FLAG, Z_FLAG, I_FLAG, INT_PENDING, INTR;
  logic lv_c, lv_z, lv_i, lv_pend, lv_intr;

  int errors = 0;
  int checks = 0;

  rat_flag_intr_unit #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .ALU_C(ALU_C), .ALU_Z(ALU_Z),
    .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR), .FLG_C_LD(FLG_C_LD),
    .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
    .I_SET(I_SET), .I_CLR(I_CLR), .INT_ACK(INT_ACK), .INT_IN(INT_IN),
    .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
    .INT_PENDING(INT_PENDING), .INTR(INTR)
  );

  rat_flag_intr_unit #(.SYNC_STAGES(3), .EDGE_MODE(1'b0)) u_lvl (
    .CLK(CLK), .RESET_N(RESET_N), .ALU_C(ALU_C), .ALU_Z(ALU_Z),
    .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR), .FLG_C_LD(FLG_C_LD),
    .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
    .I_SET(I_SET), .I_CLR(I_CLR), .INT_ACK(INT_ACK), .INT_IN(INT_IN),
    .C_FLAG(lv_c), .Z_FLAG(lv_z), .I_FLAG(lv_i),
    .INT_PENDING(lv_pend), .INTR(lv_intr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  bit m_c, m_z, m_sc, m_sz, m_i, m_pe, m_pl;
  bit ins[$];  // INT_IN as seen at each clock edge since reset release

  function automatic bit samp(int idx);
    if (idx < 0) return 1'b0;
    return ins[idx];
  endfunction

  task automatic model_reset();
    m_c = 0; m_z = 0; m_sc = 0; m_sz = 0; m_i = 0; m_pe = 0; m_pl = 0;
    ins.delete();
  endtask

  task automatic model_edge();
    bit oc, oz;
    int k;
    if (!RESET_N) return;
    oc = m_c;
    oz = m_z;
    if (FLG_C_CLR)     m_c = 0;
    else if (FLG_C_SET) m_c = 1;
    else if (FLG_C_LD)  m_c = FLG_LD_SEL ? m_sc : ALU_C;
    if (FLG_Z_LD)       m_z = FLG_LD_SEL ? m_sz : ALU_Z;
    if (FLG_SHAD_LD) begin
      m_sc = oc;
      m_sz = oz;
    end
    if (I_CLR)      m_i = 0;
    else if (I_SET) m_i = 1;
    ins.push_back(INT_IN);
    k = ins.size() - 1;
    // Synced value seen before edge k is the pin sample from STAGES edges ago;
    // the delayed copy is one sample older.
    if (samp(k - 2) && !samp(k - 3)) m_pe = 1;
    else if (INT_ACK)                m_pe = 0;
    m_pl = samp(k - 3);
  endtask

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_c"},       C_FLAG,      m_c);
    chk({tag, "_z"},       Z_FLAG,      m_z);
    chk({tag, "_i"},       I_FLAG,      m_i);
    chk({tag, "_pend"},    INT_PENDING, m_pe);
    chk({tag, "_intr"},    INTR,        m_pe & m_i);
    chk({tag, "_lv_c"},    lv_c,        m_c);
    chk({tag, "_lv_pend"}, lv_pend,     m_pl);
    chk({tag, "_lv_intr"}, lv_intr,     m_pl & m_i);
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic clear_strobes();
    FLG_C_SET = 0; FLG_C_CLR = 0; FLG_C_LD = 0; FLG_Z_LD = 0;
    FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every strobe and the pin held high.
    RESET_N = 0;
    model_reset();
    ALU_C = 1; ALU_Z = 1; INT_IN = 1;
    FLG_C_SET = 1; FLG_C_CLR = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
    FLG_LD_SEL = 1; FLG_SHAD_LD = 1; I_SET = 1; I_CLR = 1; INT_ACK = 1;
    #2;
    check_all("rst_low");
    chk("rst_low_intr_const", INTR, 1'b0);
    step("rst_edge");
    RESET_N = 1;
    step("rst_rel");
    chk("rst_rel_c_const", C_FLAG, 1'b0);
    chk("rst_rel_i_const", I_FLAG, 1'b0);

    // Pin held high through release: one request, three edges after release.
    clear_strobes();
    ALU_C = 0; ALU_Z = 0;
    step("hold1");
    chk("hold1_pend_const", INT_PENDING, 1'b0);
    step("hold2");
    chk("hold2_pend_const", INT_PENDING, 1'b1);
    step("hold3");
    INT_ACK = 1;
    step("hold_ack");
    INT_ACK = 0;
    step("hold_after");
    step("hold_after2");
    chk("single_pend_const", INT_PENDING, 1'b0);

    // Carry priority.
    FLG_C_SET = 1; FLG_C_CLR = 1; FLG_C_LD = 1; ALU_C = 1;
    step("cpri1");
    chk("cpri_clr_const", C_FLAG, 1'b0);
    FLG_C_CLR = 0; ALU_C = 0;
    step("cpri2");
    chk("cpri_set_const", C_FLAG, 1'b1);
    clear_strobes();

    // Build C=1, Z=0 with shadow (0,1), then swap.
    FLG_C_CLR = 1; FLG_Z_LD = 1; ALU_Z = 1;
    step("swp_a");
    clear_strobes();
    FLG_SHAD_LD = 1;
    step("swp_b");
    clear_strobes();
    FLG_C_SET = 1; FLG_Z_LD = 1; ALU_Z = 0;
    step("swp_c");
    clear_strobes();
    FLG_SHAD_LD = 1; FLG_C_LD = 1; FLG_Z_LD = 1; FLG_LD_SEL = 1;
    step("swap");
    chk("swap_c_const", C_FLAG, 1'b0);
    chk("swap_z_const", Z_FLAG, 1'b1);
    clear_strobes();
    FLG_C_LD = 1; FLG_Z_LD = 1; FLG_LD_SEL = 1;
    step("restore");
    chk("restore_c_const", C_FLAG, 1'b1);
    chk("restore_z_const", Z_FLAG, 1'b0);
    clear_strobes();

    // Edge latency with interrupts enabled.
    INT_IN = 0;
    step("lat_idle1");
    step("lat_idle2");
    I_SET = 1;
    step("lat_iset");
    I_SET = 0;
    INT_IN = 1;
    step("lat_n");
    chk("lat_n_pend_const", INT_PENDING, 1'b0);
    step("lat_n1");
    chk("lat_n1_pend_const", INT_PENDING, 1'b0);
    step("lat_n2");
    chk("lat_n2_pend_const", INT_PENDING, 1'b1);
    chk("lat_n2_intr_const", INTR, 1'b1);
    INT_ACK = 1;
    step("lat_ack");
    INT_ACK = 0;
    step("lat_hold1");
    step("lat_hold2");
    chk("lat_hold_pend_const", INT_PENDING, 1'b0);

    // Acknowledge colliding with a second rising edge.
    INT_IN = 0;
    repeat (3) step("col_lo1");
    INT_IN = 1;
    repeat (3) step("col_hi1");
    chk("col_first_pend_const", INT_PENDING, 1'b1);
    INT_IN = 0;
    repeat (3) step("col_lo2");
    INT_IN = 1;
    step("col_m");
    step("col_m1");
    INT_ACK = 1;
    step("col_ack");
    chk("ack_coll_pend_const", INT_PENDING, 1'b1);
    INT_ACK = 0;

    // Masking.
    I_SET = 1; I_CLR = 1;
    step("mask");
    chk("mask_i_const", I_FLAG, 1'b0);
    chk("mask_intr_const", INTR, 1'b0);
    chk("mask_pend_const", INT_PENDING, 1'b1);
    I_CLR = 0;
    step("unmask");
    chk("unmask_intr_const", INTR, 1'b1);
    I_SET = 0;

    // Reset mid-operation discards pending and shadow.
    FLG_SHAD_LD = 1;
    step("pre_mid_shad");
    FLG_SHAD_LD = 0;
    #2;
    RESET_N = 0;
    model_reset();
    #1;
    check_all("midrst");
    chk("midrst_pend_const", INT_PENDING, 1'b0);
    INT_IN = 0;
    step("midrst_edge");
    RESET_N = 1;
    FLG_C_LD = 1; FLG_Z_LD = 1; FLG_LD_SEL = 1;
    step("midrst_restore");
    chk("midrst_restore_c_const", C_FLAG, 1'b0);
    clear_strobes();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      ALU_C       = 1'($urandom_range(0, 1));
      ALU_Z       = 1'($urandom_range(0, 1));
      FLG_C_SET   = ($urandom_range(0, 5) == 0);
      FLG_C_CLR   = ($urandom_range(0, 5) == 0);
      FLG_C_LD    = ($urandom_range(0, 2) == 0);
      FLG_Z_LD    = ($urandom_range(0, 2) == 0);
      FLG_LD_SEL  = ($urandom_range(0, 2) == 0);
      FLG_SHAD_LD = ($urandom_range(0, 3) == 0);
      I_SET       = ($urandom_range(0, 4) == 0);
      I_CLR       = ($urandom_range(0, 6) == 0);
      INT_ACK     = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) INT_IN = ~INT_IN;
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
